// File: rtl/mem_ctrl_fsm.sv
// Image memory controller: buffers loaded columns, streams them to the convolution unit,
// stores results and serves them to the MCU. Define MEM_CTRL_FSM_ERR_EN for the sticky o_err flag.
module mem_ctrl_fsm #(
    parameter int unsigned NB_DATA   = 24,
    parameter int unsigned NB_RESULT = 13,
    parameter int unsigned NB_ADDR   = 10
) (
    input  logic                 i_CLK,
    input  logic                 i_rst,
    input  logic                 i_load,
    input  logic                 i_valid,
    input  logic [NB_DATA-1:0]   i_data,
    input  logic                 i_run,
    input  logic [NB_ADDR-1:0]   i_imgLength,
    input  logic [NB_ADDR-1:0]   i_req_addr,
    input  logic                 i_conv_valid,
    input  logic [NB_RESULT-1:0] i_conv_data,
    output logic                 o_conv_valid,
    output logic [NB_DATA-1:0]   o_conv_data,
    output logic [NB_RESULT-1:0] o_MCUdata,
    output logic                 o_EOP,
    output logic [2:0]           o_state,
    output logic                 o_err
);

    localparam int unsigned DEPTH = 1 << NB_ADDR;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t               state_q;
    logic [NB_ADDR-1:0]   wr_addr_q;
    logic [NB_ADDR-1:0]   rd_addr_q;
    logic [NB_ADDR-1:0]   res_cnt_q;
    logic                 conv_valid_q;
    logic [NB_DATA-1:0]   conv_data_q;
    logic [NB_RESULT-1:0] mcu_data_q;
    logic                 eop_q;

    logic [NB_DATA-1:0]   in_ram  [DEPTH];
    logic [NB_RESULT-1:0] out_ram [DEPTH];

    logic run_phase_c;
    logic mcu_phase_c;
    logic in_we_c;
    logic out_we_c;
    logic new_frame_c;

    assign run_phase_c = (state_q == RUN) || (state_q == DRAIN);
    assign mcu_phase_c = (state_q == IDLE) || (state_q == LOAD) || (state_q == DONE);
    assign in_we_c     = (state_q == LOAD) && i_valid && (wr_addr_q < i_imgLength);
    assign out_we_c    = run_phase_c && i_conv_valid && (res_cnt_q < i_imgLength);
    assign new_frame_c = (state_q == DONE) && i_load && !i_run;

    // RAM arrays are not reset; contents persist across frames and resets
    always_ff @(posedge i_CLK) begin
        if (in_we_c) begin
            in_ram[wr_addr_q] <= i_data;
        end
        if (out_we_c) begin
            out_ram[res_cnt_q] <= i_conv_data;
        end
    end

    always_ff @(posedge i_CLK or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= IDLE;
            wr_addr_q    <= '0;
            rd_addr_q    <= '0;
            res_cnt_q    <= '0;
            conv_valid_q <= 1'b0;
            conv_data_q  <= '0;
            mcu_data_q   <= '0;
            eop_q        <= 1'b0;
        end else begin
            conv_valid_q <= 1'b0;
            if (in_we_c) begin
                wr_addr_q <= wr_addr_q + NB_ADDR'(1);
            end
            if (out_we_c) begin
                res_cnt_q <= res_cnt_q + NB_ADDR'(1);
            end
            if (mcu_phase_c) begin
                mcu_data_q <= out_ram[i_req_addr];
            end

            case (state_q)
                IDLE: begin
                    if (i_load) begin
                        state_q   <= LOAD;
                        wr_addr_q <= '0;
                    end
                end
                LOAD: begin
                    if (i_run) begin
                        state_q   <= RUN;
                        rd_addr_q <= '0;
                        res_cnt_q <= '0;
                    end
                end
                RUN: begin
                    // synchronous RAM read: word appears with its strobe one cycle after issue
                    if (rd_addr_q < i_imgLength) begin
                        conv_valid_q <= 1'b1;
                        conv_data_q  <= in_ram[rd_addr_q];
                        rd_addr_q    <= rd_addr_q + NB_ADDR'(1);
                    end
                    if ((i_imgLength == '0) || (rd_addr_q >= i_imgLength - NB_ADDR'(1))) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (res_cnt_q == i_imgLength) begin
                        state_q <= DONE;
                        eop_q   <= 1'b1;
                    end
                end
                DONE: begin
                    if (new_frame_c) begin
                        state_q   <= LOAD;
                        eop_q     <= 1'b0;
                        wr_addr_q <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_conv_valid = conv_valid_q;
    assign o_conv_data  = conv_data_q;
    assign o_MCUdata    = mcu_data_q;
    assign o_EOP        = eop_q;
    assign o_state      = state_q;

`ifdef MEM_CTRL_FSM_ERR_EN
    logic err_q;
    logic err_evt_c;

    // dropped write, result beyond N, or result strobe outside the run phase
    assign err_evt_c = ((state_q == LOAD) && i_valid && (wr_addr_q >= i_imgLength))
                     || (i_conv_valid && (!run_phase_c || (res_cnt_q >= i_imgLength)));

    always_ff @(posedge i_CLK or posedge i_rst) begin
        if (i_rst) begin
            err_q <= 1'b0;
        end else if (new_frame_c) begin
            err_q <= 1'b0;
        end else if (err_evt_c) begin
            err_q <= 1'b1;
        end
    end

    assign o_err = err_q;
`else
    assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_ctrl_fsm.sv
// Scoreboard bench for mem_ctrl_fsm: expected column words are queued at load time and
// checked by a monitor on every o_conv_valid; a model convolution unit loops results back.
module tb_mem_ctrl_fsm;

    logic        clk;
    logic        rst;
    logic        i_load;
    logic        i_valid;
    logic [23:0] i_data;
    logic        i_run;
    logic [9:0]  i_imgLength;
    logic [9:0]  i_req_addr;
    logic        i_conv_valid;
    logic [12:0] i_conv_data;
    logic        o_conv_valid;
    logic [23:0] o_conv_data;
    logic [12:0] o_MCUdata;
    logic        o_EOP;
    logic [2:0]  o_state;
    logic        o_err;

    mem_ctrl_fsm dut (
        .i_CLK        (clk),
        .i_rst        (rst),
        .i_load       (i_load),
        .i_valid      (i_valid),
        .i_data       (i_data),
        .i_run        (i_run),
        .i_imgLength  (i_imgLength),
        .i_req_addr   (i_req_addr),
        .i_conv_valid (i_conv_valid),
        .i_conv_data  (i_conv_data),
        .o_conv_valid (o_conv_valid),
        .o_conv_data  (o_conv_data),
        .o_MCUdata    (o_MCUdata),
        .o_EOP        (o_EOP),
        .o_state      (o_state),
        .o_err        (o_err)
    );

`ifdef MEM_CTRL_FSM_ERR_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    int errors = 0;
    int checks = 0;
    logic [23:0] conv_q [$];

    int cyc = 0;
    int last_res_cyc = 0;
    int run_cyc = 0;
    int strobe_n = 0;
    int strobes_seen = 0;
    logic [2:0] prev_state = 3'd0;
    logic eop_prev = 1'b0;
    bit chk_eop = 1'b1;
    int res_tag = 0;
    int res_idx = 0;
    logic [2:0] sr = 3'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (i_conv_valid) last_res_cyc <= cyc + 1;
    end

    // convolution unit model: returns one result 3 cycles after each column strobe
    always @(negedge clk) begin
        if (rst) begin
            sr = 3'd0;
            i_conv_valid = 1'b0;
        end else begin
            if (o_state == 3'd1) res_idx = 0;
            i_conv_valid = sr[1];
            if (sr[1]) begin
                i_conv_data = 13'((res_tag << 8) | (res_idx + 1));
                res_idx++;
            end
            sr = {sr[1:0], o_conv_valid};
        end
    end

    // monitor: pops the scoreboard on every column strobe and checks EOP timing
    always @(negedge clk) begin
        if (!rst) begin
            if (o_state == 3'd2 && prev_state != 3'd2) begin
                run_cyc = cyc;
                strobe_n = 0;
            end
            if (o_conv_valid) begin
                if (conv_q.size() == 0) begin
                    chk("conv_unexpected", 32'(o_conv_valid), 32'd0);
                end else begin
                    chk("conv_data", 32'(o_conv_data), 32'(conv_q.pop_front()));
                    chk("conv_timing", 32'(cyc), 32'(run_cyc + 1 + strobe_n));
                end
                strobe_n++;
                strobes_seen++;
            end
            if (o_EOP && !eop_prev && chk_eop)
                chk("eop_timing", 32'(cyc), 32'(last_res_cyc + 1));
        end
        prev_state = o_state;
        eop_prev = o_EOP;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic start_frame(input logic [9:0] n, input int tag);
        i_imgLength = n;
        res_tag = tag;
        i_load = 1'b1;
        i_run = 1'b0;
        tick();
        chk("frame_state", 32'(o_state), 32'd1);
        chk("frame_eop", 32'(o_EOP), 32'd0);
        chk("frame_err", 32'(o_err), 32'd0);
    endtask

    task automatic write_word(input logic [23:0] w, input bit keep);
        i_valid = 1'b1;
        i_data = w;
        if (keep) conv_q.push_back(w);
        tick();
        i_valid = 1'b0;
    endtask

    task automatic wait_eop();
        for (int i = 0; i < 200 && !o_EOP; i++) tick();
        chk("eop_seen", 32'(o_EOP), 32'd1);
        chk("state_done", 32'(o_state), 32'd4);
        chk("queue_empty", 32'(conv_q.size()), 32'd0);
    endtask

    task automatic mcu_read(input logic [9:0] addr, input logic [12:0] exp);
        i_req_addr = addr;
        tick();
        chk("mcu_data", 32'(o_MCUdata), 32'(exp));
    endtask

    initial begin
        rst = 1'b1;
        i_load = 1'b0;
        i_valid = 1'b0;
        i_data = '0;
        i_run = 1'b0;
        i_imgLength = '0;
        i_req_addr = '0;
        i_conv_valid = 1'b0;
        i_conv_data = '0;
        tick();
        tick();
        chk("rst_state", 32'(o_state), 32'd0);
        chk("rst_conv_valid", 32'(o_conv_valid), 32'd0);
        chk("rst_conv_data", 32'(o_conv_data), 32'd0);
        chk("rst_mcu", 32'(o_MCUdata), 32'd0);
        chk("rst_eop", 32'(o_EOP), 32'd0);
        chk("rst_err", 32'(o_err), 32'd0);
        rst = 1'b0;
        tick();

        // frame 1: N=4 load/run/readback
        start_frame(10'd4, 0);
        write_word(24'h010203, 1'b1);
        write_word(24'h040506, 1'b1);
        write_word(24'h070809, 1'b1);
        write_word(24'h0A0B0C, 1'b1);
        i_load = 1'b0;
        i_run = 1'b1;
        tick();
        wait_eop();
        mcu_read(10'd2, 13'h0003);
        mcu_read(10'd0, 13'h0001);
        mcu_read(10'd3, 13'h0004);

        // frame 2: N=2 with one write past the end
        start_frame(10'd2, 1);
        write_word(24'h111111, 1'b1);
        write_word(24'h222222, 1'b1);
        write_word(24'h333333, 1'b0);
        tick();
        chk("overflow_err", 32'(o_err), 32'(ERR_EXP));
        i_load = 1'b0;
        i_run = 1'b1;
        tick();
        wait_eop();
        mcu_read(10'd0, 13'h0101);
        mcu_read(10'd1, 13'h0102);
        mcu_read(10'd2, 13'h0003);

        // frame 3: N=2, second write coincides with the run edge
        start_frame(10'd2, 2);
        write_word(24'hAAAA01, 1'b1);
        i_valid = 1'b1;
        i_data = 24'hBBBB02;
        conv_q.push_back(24'hBBBB02);
        i_load = 1'b0;
        i_run = 1'b1;
        tick();
        i_valid = 1'b0;
        wait_eop();
        mcu_read(10'd1, 13'h0202);

        // frame 4: zero length
        chk_eop = 1'b0;
        start_frame(10'd0, 3);
        i_load = 1'b0;
        i_run = 1'b1;
        tick();
        chk("zero_run_state", 32'(o_state), 32'd2);
        tick();
        chk("zero_drain_state", 32'(o_state), 32'd3);
        chk("zero_eop_early", 32'(o_EOP), 32'd0);
        tick();
        chk("zero_eop", 32'(o_EOP), 32'd1);
        chk("zero_done_state", 32'(o_state), 32'd4);
        mcu_read(10'd1, 13'h0202);
        chk_eop = 1'b1;

        // frame 5: N=5, async reset after two strobes
        start_frame(10'd5, 3);
        for (int i = 0; i < 5; i++) write_word(24'h500000 + 24'(i), 1'b1);
        begin
            int base;
            base = strobes_seen;
            i_load = 1'b0;
            i_run = 1'b1;
            for (int i = 0; i < 50 && strobes_seen - base < 2; i++) tick();
            chk("mid_run_strobes", 32'(strobes_seen - base), 32'd2);
        end
        #2 rst = 1'b1;
        #1;
        chk("arst_state", 32'(o_state), 32'd0);
        chk("arst_conv_valid", 32'(o_conv_valid), 32'd0);
        chk("arst_conv_data", 32'(o_conv_data), 32'd0);
        chk("arst_mcu", 32'(o_MCUdata), 32'd0);
        chk("arst_eop", 32'(o_EOP), 32'd0);
        conv_q.delete();
        i_run = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // frame 6: full N=5 frame after reset
        start_frame(10'd5, 4);
        for (int i = 0; i < 5; i++) write_word(24'h600010 + 24'(i), 1'b1);
        i_load = 1'b0;
        i_run = 1'b1;
        tick();
        wait_eop();
        mcu_read(10'd4, 13'h0405);
        mcu_read(10'd0, 13'h0401);

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_ctrl_fsm.md
Name: mem_ctrl_fsm

Overview:
Image memory controller that sits directly downstream of the control block, driven by its load/valid/run/imgLength/GPIOdata outputs and returning EOP and MCU read data. During load it writes packed 3-pixel columns (24 bits) into an input RAM. During run it streams the columns to the convolution unit and stores the 13-bit results in an output RAM. At the end of processing it raises EOP and serves results to the MCU by address.

Parameters:
NB_DATA, 24, input word width (3 x 8-bit pixels, one kernel-height column)
NB_RESULT, 13, convolution result width
NB_ADDR, 10, address width; RAM depth = 2**NB_ADDR (1024)

Ports:
i_CLK  in  1  system clock, rising edge
i_rst  in  1  asynchronous, active-high reset
i_load  in  1  load-phase level from control block
i_valid  in  1  one-cycle write strobe for i_data (already edge-detected upstream)
i_data  in  NB_DATA  input column word
i_run  in  1  run-phase level from control block
i_imgLength  in  NB_ADDR  number of columns N to process
i_req_addr  in  NB_ADDR  MCU result read address
i_conv_valid  in  1  result strobe from convolution unit
i_conv_data  in  NB_RESULT  convolution result
o_conv_valid  out  1  column strobe to convolution unit
o_conv_data  out  NB_DATA  column word to convolution unit
o_MCUdata  out  NB_RESULT  result read for MCU
o_EOP  out  1  end of process (level)
o_state  out  3  current state encoding, for LEDs/debug
o_err  out  1  sticky error flag (see Optional Feature)

Behaviour:
- Reset (async, i_rst=1): state IDLE; wr_addr, rd_addr, res_cnt = 0; o_conv_valid=0; o_conv_data=0; o_MCUdata=0; o_EOP=0; o_err=0. RAM contents are not cleared.
- State encoding: IDLE=0, LOAD=1, RUN=2, DRAIN=3, DONE=4.
- IDLE: i_load=1 -> LOAD, wr_addr cleared.
- LOAD:
  - i_valid=1 and wr_addr<N: in_ram[wr_addr]<=i_data, wr_addr++.
  - i_valid=1 and wr_addr>=N: write dropped (error event).
  - i_run=1 -> RUN with rd_addr=0, res_cnt=0. Simultaneous i_valid and i_run: the write is performed, then the transition.
- RUN:
  - Issues a read of in_ram[rd_addr] every cycle, rd_addr++.
  - RAM read latency is 1; o_conv_valid=1 and o_conv_data=word exactly one cycle after each read issue, so there are N back-to-back strobes.
  - After the read of address N-1 -> DRAIN.
  - N=0: no reads, no strobes, go directly to DRAIN.
  - i_valid ignored in RUN.
- Result capture (RUN and DRAIN): i_conv_valid=1 -> out_ram[res_cnt]<=i_conv_data, res_cnt++. Results beyond count N are dropped (error event).
- DRAIN: res_cnt==N -> DONE. N=0 gives DONE on the next cycle.
- DONE: o_EOP=1, registered, held. A rising i_load (i_load=1 while i_run=0) -> LOAD with o_EOP cleared the same edge and wr_addr=0. This starts a new frame.
- MCU read-out: in IDLE, LOAD and DONE, o_MCUdata <= out_ram[i_req_addr] every cycle (1-cycle latency). o_MCUdata holds its value during RUN/DRAIN.
- i_conv_valid outside RUN/DRAIN is ignored (error event).
- o_state = current state, registered.
- Counters never wrap. wr_addr and res_cnt saturate at N, rd_addr stops at N.

Optional Feature:
Macro MEM_CTRL_FSM_ERR_EN.
- Defined: o_err is set sticky on any error event (write past N in LOAD, result past N, i_conv_valid outside RUN/DRAIN). It is cleared only by i_rst or by the DONE->LOAD transition.
- Not defined: o_err is tied to 0, error detection logic is absent, and drop behaviour is unchanged.

Test Plan:
- Load/run/readback: N=4, load columns 0x010203, 0x040506, 0x070809, 0x0A0B0C, then i_run. Expect 4 consecutive o_conv_valid pulses starting 1 cycle after entering RUN, carrying exactly those words. Loopback results 0x0001..0x0004 with latency 3; o_EOP rises 1 cycle after the 4th result. Then i_req_addr=2 -> o_MCUdata=0x0003 the next cycle.
- Overflow: N=2, 3 i_valid strobes. in_ram[0..1] hold the first two words; the third is dropped and o_err=1 (macro defined) or 0 (undefined).
- Simultaneous i_valid+i_run on the same edge with wr_addr=1, N=2: the word is written at address 1, and RUN streams 2 columns including it.
- Zero length: N=0, i_load then i_run. No o_conv_valid; o_EOP=1 two cycles after the run edge.
- Async reset mid-RUN (after 2 of 5 strobes): outputs go to reset values immediately without a clock edge, and state=IDLE. A subsequent full frame with N=5 completes normally.
- New frame after DONE: with o_EOP=1, assert i_load. o_EOP=0 and state=LOAD on the next edge; the second frame's results overwrite out_ram.
